fifo_rd_stream: RTL and testbench

Read-side drain stage for the dual-clock `fifo2`, running entirely in the read clock domain. Pops words from the FIFO's `rdata`/`rempty`/`rinc` port and re-presents them as a registered valid/ready stream through a 2-entry skid buffer, sustaining one word per `rclk` cycle under continuous backpressure-free flow. Also keeps a delivered-word counter and an optional sequence checker for the incrementing-data traffic used on the FIFO bench.

---
 rtl/fifo_rd_stream.sv | 100 ++++++++++
 tb/tb_fifo_rd_stream.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for fifo2: pops the FWFT head into a 2-entry skid buffer and presents a registered valid/ready stream.
// Optional build macro FIFO_RD_SEQ_CHECK_EN enables the incrementing-data sequence checker.
module fifo_rd_stream #(
  parameter int DSIZE = 32,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             rd_en,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNTW-1:0]  dcount,
  output logic             seq_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t             cnt, cnt_next;
  logic [DSIZE-1:0] slot [2];
  logic             head, tail, head_next;
  logic             push, pop;
  logic [DSIZE-1:0] head_data_next;

  // Gating with rrst_n keeps the FIFO untouched while this block is held in reset.
  assign rinc = rrst_n & rd_en & ~rempty & (cnt != TWO);
  assign push = rinc;
  assign pop  = out_valid & out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_next = cnt;
    unique case ({push, pop})
      2'b10:   cnt_next = (cnt == EMPTY) ? ONE : TWO;
      2'b01:   cnt_next = (cnt == TWO) ? ONE : EMPTY;
      default: cnt_next = cnt;
    endcase
  end

  // A push lands on the new head only when the buffer would otherwise be empty.
  assign head_next      = head ^ pop;
  assign head_data_next = (push && (tail == head_next)) ? rdata : slot[head_next];

  // NOTE: data slots carry no reset; occupancy and out_valid decide whether they matter.
  always_ff @(posedge rclk) begin
    if (push) slot[tail] <= rdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt       <= EMPTY;
      head      <= 1'b0;
      tail      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      dcount    <= '0;
    end else begin
      cnt       <= cnt_next;
      head      <= head_next;
      tail      <= tail ^ push;
      out_valid <= (cnt_next != EMPTY);
      if (cnt_next != EMPTY) out_data <= head_data_next;
      if (pop) dcount <= dcount + CNTW'(1);
    end
  end

`ifdef FIFO_RD_SEQ_CHECK_EN
  logic [DSIZE-1:0] exp_word;
  logic             exp_loaded;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      exp_word   <= '0;
      exp_loaded <= 1'b0;
      seq_err    <= 1'b0;
      err_cnt    <= 8'd0;
    end else if (push) begin
      exp_word   <= rdata + DSIZE'(1);
      exp_loaded <= 1'b1;
      if (exp_loaded && (rdata != exp_word)) begin
        seq_err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`else
  assign seq_err = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-backed FWFT FIFO model feeds the DUT, popped words are expected in order at the stream side.
module tb_fifo_rd_stream;
  localparam int DSIZE = 32;
  localparam int CNTW  = 16;

  logic             rclk;
  logic             rrst_n;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic             rd_en;
  logic [DSIZE-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNTW-1:0]  dcount;
  logic             seq_err;
  logic [7:0]       err_cnt;

  fifo_rd_stream #(.DSIZE(DSIZE), .CNTW(CNTW)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .rd_en(rd_en), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .dcount(dcount), .seq_err(seq_err), .err_cnt(err_cnt)
  );

  int               total = 0;
  int               bad   = 0;
  logic [DSIZE-1:0] src_q [$];
  logic [DSIZE-1:0] exp_q [$];
  bit               empty_force = 1'b0;
  logic [CNTW-1:0]  n_deliv = '0;

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic refresh();
    rdata  = (src_q.size() != 0) ? src_q[0] : '0;
    rempty = (src_q.size() == 0) || empty_force;
  endtask

  // FIFO model: pops at the edge where rinc is high, records the word as expected output.
  always begin
    @(posedge rclk);
    if (!rrst_n) exp_q.delete();
    else if (rinc && src_q.size() != 0) exp_q.push_back(src_q.pop_front());
    #1;
    refresh();
  end

  // Monitor: on the falling edge, a visible handshake will complete at the next rising edge.
  always @(negedge rclk) begin
    if (!rrst_n) begin
      n_deliv = '0;
    end else begin
      check("dcount_track", 64'(dcount), 64'(n_deliv));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_word", 64'(out_data), 64'hDEAD_BEEF);
        else check("stream_data", 64'(out_data), 64'(exp_q.pop_front()));
        n_deliv = n_deliv + 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge rclk);
    #2;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (src_q.size() == 0 && exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    check("drain_done", 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    repeat (2) step();
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n    = 1'b0;
    rd_en     = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) src_q.push_back(DSIZE'(i));
    refresh();

    // Reset with a non-empty FIFO
    repeat (2) @(negedge rclk);
    check("rst_rinc", 64'(rinc), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_dcount", 64'(dcount), 64'd0);
    check("rst_seq_err", 64'(seq_err), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    step();
    rrst_n = 1'b1;
    @(negedge rclk);
    check("first_rinc", 64'(rinc), 64'd1);
    check("pre_valid", 64'(out_valid), 64'd0);

    // Stream 1..100: word k visible right after edge k
    for (int k = 1; k <= 100; k++) begin
      @(negedge rclk);
      check("cadence_valid", 64'(out_valid), 64'd1);
      check("cadence_data", 64'(out_data), 64'(k));
    end
    check("dcount_99", 64'(dcount), 64'd99);
    @(negedge rclk);
    check("stream_end_valid", 64'(out_valid), 64'd0);
    check("dcount_100", 64'(dcount), 64'd100);
    check("stream_seq_err", 64'(seq_err), 64'd0);

    // Backpressure for 5 cycles while word 110 is presented
    step();
    for (int i = 101; i <= 130; i++) src_q.push_back(DSIZE'(i));
    refresh();
    for (int k = 1; k <= 10; k++) step();
    check("bp_head", 64'(out_data), 64'd110);
    out_ready = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      step();
      check("bp_rinc", 64'(rinc), 64'd0);
      check("bp_hold", 64'(out_data), 64'd110);
      check("bp_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    step();
    check("bp_resume", 64'(out_data), 64'd111);
    drain();
    check("dcount_130", 64'(dcount), 64'd130);

    // rempty toggling and rd_en low window
    for (int i = 131; i <= 160; i++) src_q.push_back(DSIZE'(i));
    for (int i = 0; i < 40; i++) begin
      step();
      empty_force = i[0];
      rd_en = !(i >= 20 && i <= 25);
      refresh();
      #1;
      check("gate_rinc", 64'(rinc), 64'(rd_en && !empty_force && src_q.size() != 0));
    end
    empty_force = 1'b0;
    rd_en = 1'b1;
    refresh();
    drain();
    check("dcount_160", 64'(dcount), 64'd160);

    // Reset while the buffer is full
    out_ready = 1'b0;
    for (int i = 200; i <= 209; i++) src_q.push_back(DSIZE'(i));
    refresh();
    repeat (3) step();
    check("full_rinc", 64'(rinc), 64'd0);
    rrst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_dcount", 64'(dcount), 64'd0);
    check("mid_rst_rinc", 64'(rinc), 64'd0);
    repeat (2) step();
    out_ready = 1'b1;
    rrst_n = 1'b1;
    step();
    check("post_rst_word", 64'(out_data), 64'd202);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    drain();
    check("dcount_restart", 64'(dcount), 64'd8);

    // Sequence checker: 1,2,3,7,8,8
    do_reset();
    src_q.push_back(32'd1); src_q.push_back(32'd2); src_q.push_back(32'd3);
    src_q.push_back(32'd7); src_q.push_back(32'd8); src_q.push_back(32'd8);
    refresh();
    drain();
`ifdef FIFO_RD_SEQ_CHECK_EN
    check("seq_err", 64'(seq_err), 64'd1);
    check("err_cnt", 64'(err_cnt), 64'd2);
`else
    check("seq_err", 64'(seq_err), 64'd0);
    check("err_cnt", 64'(err_cnt), 64'd0);
`endif
    check("dcount_seq", 64'(dcount), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
